// File: rtl/hls_run_controller.sv
// Run sequencer for an HLS accelerator: resets it, starts it and times each run of a batch,
// keeping last/min/max/total cycle statistics and a sticky timeout flag.
module hls_run_controller #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RUNS_W     = 8,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      abort,
    input  logic [RUNS_W-1:0]         cfg_runs,
    output logic                      dut_reset,
    output logic                      start_port,
    input  logic                      done_port,
    output logic                      busy,
    output logic [RUNS_W-1:0]         run_idx,
    output logic                      result_valid,
    output logic [CNT_W-1:0]          last_cycles,
    output logic [CNT_W-1:0]          min_cycles,
    output logic [CNT_W-1:0]          max_cycles,
    output logic [CNT_W+RUNS_W-1:0]   total_cycles,
    output logic                      timeout_flag,
    output logic                      finished
);

    localparam int unsigned TOT_W = CNT_W + RUNS_W;
    localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DUTRST = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4,
        END    = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [RC_W-1:0]     rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [RUNS_W-1:0]   runs_q, runs_nxt;
    logic [RUNS_W-1:0]   run_idx_nxt;
    logic [CNT_W-1:0]    last_nxt, min_nxt, max_nxt;
    logic [TOT_W-1:0]    total_nxt;
    logic                tflag_nxt;
    logic                rv_nxt;

    // Next-state and datapath update; abort overrides every non-IDLE state except END.
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        cnt_nxt     = cnt;
        runs_nxt    = runs_q;
        run_idx_nxt = run_idx;
        last_nxt    = last_cycles;
        min_nxt     = min_cycles;
        max_nxt     = max_cycles;
        total_nxt   = total_cycles;
        tflag_nxt   = timeout_flag;
        rv_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    runs_nxt    = cfg_runs;
                    run_idx_nxt = '0;
                    rst_cnt_nxt = '0;
                    last_nxt    = '0;
                    min_nxt     = '1;
                    max_nxt     = '0;
                    total_nxt   = '0;
                    tflag_nxt   = 1'b0;
                    state_nxt   = (cfg_runs == '0) ? END : DUTRST;
                end
            end
            DUTRST: begin
                if (abort) begin
                    state_nxt = END;
                end else if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = START;
                end else begin
                    rst_cnt_nxt = rst_cnt + RC_W'(1);
                end
            end
            START: begin
                if (abort) begin
                    state_nxt = END;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = END;
                end else if (done_port) begin
                    // Completion wins over a timeout in the same cycle.
                    last_nxt  = cnt;
                    total_nxt = total_cycles + TOT_W'(cnt);
                    min_nxt   = (cnt < min_cycles) ? cnt : min_cycles;
                    max_nxt   = (cnt > max_cycles) ? cnt : max_cycles;
                    rv_nxt    = 1'b1;
                    state_nxt = REPORT;
                end else if (cnt >= CNT_W'(TIMEOUT)) begin
                    tflag_nxt = 1'b1;
                    state_nxt = END;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REPORT: begin
                if (abort || (run_idx == runs_q - RUNS_W'(1))) begin
                    state_nxt = END;
                end else begin
                    run_idx_nxt = run_idx + RUNS_W'(1);
                    rst_cnt_nxt = '0;
                    state_nxt   = DUTRST;
                end
            end
            END: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and outputs registered together so outputs line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            cnt          <= '0;
            runs_q       <= '0;
            run_idx      <= '0;
            last_cycles  <= '0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
            timeout_flag <= 1'b0;
            result_valid <= 1'b0;
            dut_reset    <= 1'b0;
            start_port   <= 1'b0;
            busy         <= 1'b0;
            finished     <= 1'b0;
        end else begin
            state        <= state_nxt;
            rst_cnt      <= rst_cnt_nxt;
            cnt          <= cnt_nxt;
            runs_q       <= runs_nxt;
            run_idx      <= run_idx_nxt;
            last_cycles  <= last_nxt;
            min_cycles   <= min_nxt;
            max_cycles   <= max_nxt;
            total_cycles <= total_nxt;
            timeout_flag <= tflag_nxt;
            result_valid <= rv_nxt;
            dut_reset    <= (state_nxt != DUTRST);
            start_port   <= (state_nxt == START);
            busy         <= (state_nxt != IDLE);
            finished     <= (state_nxt == END);
        end
    end

endmodule

// File: doc/hls_run_controller.md
HLS_RUN_CONTROLLER -- requirements
Module: hls_run_controller

Interface
REQ-001 Parameter CNT_W, default 32: width of the per-run cycle counter and the cycle statistics outputs.
REQ-002 Parameter RUNS_W, default 8: width of the run-count configuration and the run index.
REQ-003 Parameter TIMEOUT, default 200000000: per-run cycle limit; TIMEOUT < 2^CNT_W.
REQ-004 Parameter RST_CYCLES, default 2: number of cycles dut_reset is held low before each run; must be >= 1.
REQ-005 Port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port go, input, 1 bit: request a batch of runs; sampled only in IDLE.
REQ-008 Port abort, input, 1 bit: terminate the batch; sampled in every state except IDLE.
REQ-009 Port cfg_runs, input, RUNS_W bits: number of runs in the batch; latched when go is accepted.
REQ-010 Port dut_reset, output, 1 bit: active-low reset driven to the accelerator.
REQ-011 Port start_port, output, 1 bit: one-cycle start pulse driven to the accelerator.
REQ-012 Port done_port, input, 1 bit: completion pulse from the accelerator.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port run_idx, output, RUNS_W bits: zero-based index of the current or last run.
REQ-015 Port result_valid, output, 1 bit: one-cycle pulse when last_cycles updates.
REQ-016 Port last_cycles, output, CNT_W bits: cycle count of the most recent completed run.
REQ-017 Port min_cycles, output, CNT_W bits: minimum completed-run cycle count in the batch.
REQ-018 Port max_cycles, output, CNT_W bits: maximum completed-run cycle count in the batch.
REQ-019 Port total_cycles, output, CNT_W+RUNS_W bits: sum of completed-run cycle counts in the batch; cannot overflow.
REQ-020 Port timeout_flag, output, 1 bit: sticky; set when a run reaches TIMEOUT.
REQ-021 Port finished, output, 1 bit: one-cycle pulse when the batch ends, whatever the cause.

Function
REQ-022 The FSM SHALL have the states IDLE, DUTRST, START, WAIT, REPORT and END.
REQ-023 IDLE: on go=1, latch cfg_runs, clear the statistics and timeout_flag, and set run_idx=0.
  - If cfg_runs=0, go to END.
  - Otherwise, go to DUTRST.
REQ-024 DUTRST: dut_reset=0 for exactly RST_CYCLES cycles, then go to START; dut_reset=1 in all other states.
REQ-025 START: lasts one cycle with start_port=1; the cycle counter loads 1; go to WAIT.
REQ-026 WAIT: the counter increments by 1 each cycle; the counter value in the cycle done_port=1 is the run's cycle count.
  - Example: done 3 cycles after the start cycle gives a count of 4.
REQ-027 done_port SHALL be ignored outside WAIT, including in the START cycle.
REQ-028 On done in WAIT, go to REPORT; in REPORT, update the outputs and pulse result_valid.
  - last_cycles = count; total_cycles += count.
  - min_cycles = min(min_cycles, count); max_cycles = max(max_cycles, count).
REQ-029 From REPORT:
  - If run_idx = latched runs - 1, go to END.
  - Otherwise, increment run_idx and go to DUTRST.
REQ-030 Timeout: if WAIT reaches count = TIMEOUT with done_port=0, then:
  - set timeout_flag;
  - do not update the statistics or pulse result_valid;
  - go to END; the remaining runs are skipped.
REQ-031 If done_port=1 in the same cycle that count = TIMEOUT, the run SHALL complete normally and timeout_flag SHALL stay clear.
REQ-032 abort=1 in any non-IDLE state SHALL force END on the next edge.
  - Statistics already reported are retained.
  - An abort in the REPORT cycle still applies that cycle's update.
REQ-033 END: lasts one cycle with finished=1, then go to IDLE; all results are held until the next accepted go.
REQ-034 go received while busy=1 SHALL be ignored.
REQ-035 The cleared statistics values are last_cycles=0, min_cycles=all-ones, max_cycles=0 and total_cycles=0.

Reset
REQ-036 reset=0 SHALL immediately and asynchronously apply the following values:
  - state IDLE, dut_reset=0, start_port=0;
  - busy=0, run_idx=0, result_valid=0, finished=0, timeout_flag=0;
  - statistics at their cleared values.
REQ-037 A reset asserted mid-run SHALL abandon the batch without a finished pulse; after release, the block waits in IDLE for go.
REQ-038 After reset release, dut_reset SHALL be 1 while in IDLE.

Verification
REQ-039 cfg_runs=3 and a DUT answering done 3, 5 and 4 cycles after start, with defaults -> three result_valid pulses with last_cycles 4, 6, 5; then min=4, max=6, total=15 and one finished pulse.
REQ-040 RST_CYCLES=2 -> before each start_port pulse, dut_reset is low for exactly 2 cycles; start_port is high for exactly 1 cycle per run.
REQ-041 TIMEOUT=10, cfg_runs=2, DUT never done -> timeout_flag=1 after the 10th count cycle, no result_valid, finished pulses, run_idx=0.
REQ-042 TIMEOUT=10 with done on count 10 -> last_cycles=10 and timeout_flag=0; done asserted during START is ignored.
REQ-043 cfg_runs=0 -> finished pulses 2 cycles after go, with no dut_reset or start_port activity and min_cycles=all-ones.
REQ-044 Abort during WAIT of run 1 of 4 -> the run 0 statistics are kept, finished pulses, then IDLE; reset asserted mid-WAIT -> all outputs are at reset values immediately.
